vc_lru_tracker: RTL and testbench

//  Parametrised true-LRU order tracker for the victim cache. Stores one order list per set (slot 0 = MRU, slot WAYS-1 = LRU).

---
 rtl/vc_lru_tracker_pkg.sv | 15 +
 rtl/vc_lru_update.sv | 55 +++++
 rtl/vc_lru_tracker.sv | 134 +++++++++++++
 tb/tb_vc_lru_tracker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vc_lru_tracker_pkg.sv
// Shared types for the victim-cache LRU tracker.
// Op codes and FSM state encodings.
package vc_lru_tracker_pkg;

    typedef enum logic {
        LRU_TOUCH = 1'b0,
        LRU_INVAL = 1'b1
    } lru_op_t;

    typedef enum logic {
        LRU_INIT = 1'b0,
        LRU_IDLE = 1'b1
    } lru_fsm_t;

endpackage

// File: rtl/vc_lru_update.sv
// Combinational LRU order permutation: touch promotes a way to MRU.
// With VC_LRU_INVAL_EN defined, invalidate demotes a way to LRU.
module vc_lru_update
    import vc_lru_tracker_pkg::*;
#(
    parameter int WAYS = 8,
    parameter int IDXW = $clog2(WAYS)
) (
    input  logic [WAYS*IDXW-1:0] order_in,
    input  logic [IDXW-1:0]      way,
    input  lru_op_t              op,
    output logic [WAYS*IDXW-1:0] order_out
);

    int                    pos;
    logic [WAYS*IDXW-1:0] touched;
`ifdef VC_LRU_INVAL_EN
    logic [WAYS*IDXW-1:0] demoted;
`endif

    // Locate the way, then build the promoted (and demoted) orders
    always_comb begin
        pos = 0;
        for (int i = 0; i < WAYS; i++) begin
            if (order_in[i*IDXW +: IDXW] == way) pos = i;
        end
        touched = order_in;
        touched[0 +: IDXW] = way;
        for (int i = 1; i < WAYS; i++) begin
            if (i <= pos) touched[i*IDXW +: IDXW] = order_in[(i-1)*IDXW +: IDXW];
        end
`ifdef VC_LRU_INVAL_EN
        demoted = order_in;
        demoted[(WAYS-1)*IDXW +: IDXW] = way;
        for (int i = 0; i < WAYS - 1; i++) begin
            if (i >= pos) demoted[i*IDXW +: IDXW] = order_in[(i+1)*IDXW +: IDXW];
        end
`endif
    end

    // Select result by op; invalidate is a no-op when not built
    always_comb begin
        order_out = order_in;
        unique case (op)
            LRU_TOUCH: order_out = touched;
`ifdef VC_LRU_INVAL_EN
            LRU_INVAL: order_out = demoted;
`else
            LRU_INVAL: order_out = order_in;
`endif
            default:   order_out = order_in;
        endcase
    end

endmodule

// File: rtl/vc_lru_tracker.sv
// True-LRU order tracker: per-set order list, init sweep, registered query.
// Optional invalidate support selected by VC_LRU_INVAL_EN.
module vc_lru_tracker
    import vc_lru_tracker_pkg::*;
#(
    parameter int WAYS = 8,
    parameter int SETS = 1,
    localparam int IDXW = $clog2(WAYS),
    localparam int SETW = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 init_done,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [SETW-1:0]      req_set,
    input  logic [IDXW-1:0]      req_way,
    input  logic                 query_valid,
    input  logic [SETW-1:0]      query_set,
    output logic                 victim_valid,
    output logic [IDXW-1:0]      victim_way,
    output logic [WAYS*IDXW-1:0] order_out
);

    localparam int OW = WAYS * IDXW;

    function automatic logic [OW-1:0] reset_order();
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < WAYS; i++) r[i*IDXW +: IDXW] = IDXW'(i);
        return r;
    endfunction

    localparam logic [OW-1:0] RST_ORD = reset_order();

    lru_fsm_t        state_q, state_d;
    logic [SETW-1:0] ptr_q, ptr_d;
    logic            vv_q, vv_d;
    logic [OW-1:0]   order_q, order_d;
    logic [OW-1:0]   mem_q [SETS];

    logic            idle;
    logic            accept;
    logic            set_ok;
    logic            q_ok;
    logic            fwd;
    logic [OW-1:0]   upd_order;
    logic            wr_en;
    logic [SETW-1:0] wr_set;
    logic [OW-1:0]   wr_data;

    assign idle   = (state_q == LRU_IDLE);
    assign accept = req_valid & idle;
    assign set_ok = {1'b0, req_set} < (SETW+1)'(SETS);
    assign q_ok   = {1'b0, query_set} < (SETW+1)'(SETS);
    assign fwd    = accept & set_ok & (req_set == query_set);

    vc_lru_update #(
        .WAYS (WAYS),
        .IDXW (IDXW)
    ) u_update (
        .order_in  (mem_q[req_set]),
        .way       (req_way),
        .op        (lru_op_t'(req_op)),
        .order_out (upd_order)
    );

    // Next state of the init sweep / idle FSM
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            LRU_INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == SETW'(SETS - 1)) state_d = LRU_IDLE;
            end
            LRU_IDLE: state_d = LRU_IDLE;
            default:  state_d = LRU_INIT;
        endcase
    end

    // Order-array write port: sweep writes reset order, idle commits updates
    always_comb begin
        wr_en   = 1'b0;
        wr_set  = req_set;
        wr_data = upd_order;
        if (!idle) begin
            wr_en   = 1'b1;
            wr_set  = ptr_q;
            wr_data = RST_ORD;
        end else begin
            wr_en = accept & set_ok;
        end
    end

    // Query result: write-first forwarding from a same-set update
    always_comb begin
        vv_d    = query_valid & idle;
        order_d = order_q;
        if (vv_d) begin
            if (!q_ok) order_d = '0;
            else if (fwd) order_d = upd_order;
            else order_d = mem_q[query_set];
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LRU_INIT;
            ptr_q   <= '0;
            vv_q    <= 1'b0;
            order_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            vv_q    <= vv_d;
            order_q <= order_d;
        end
    end

    // Order storage, rewritten by the sweep so it needs no reset
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_set] <= wr_data;
    end

    assign init_done    = idle;
    assign req_ready    = idle;
    assign victim_valid = vv_q;
    assign victim_way   = order_q[(WAYS-1)*IDXW +: IDXW];
    assign order_out    = order_q;

endmodule

// File: tb/tb_vc_lru_tracker.sv
// Testbench for vc_lru_tracker (WAYS=8, SETS=4).
// Queue-based LRU model checked every cycle plus literal spot checks.
module tb_vc_lru_tracker;

    localparam int WAYS = 8;
    localparam int SETS = 4;
    localparam int IDXW = 3;
    localparam int SETW = 2;

    logic            clk;
    logic            rst_n;
    logic            init_done;
    logic            req_valid;
    logic            req_ready;
    logic            req_op;
    logic [SETW-1:0] req_set;
    logic [IDXW-1:0] req_way;
    logic            query_valid;
    logic [SETW-1:0] query_set;
    logic            victim_valid;
    logic [IDXW-1:0] victim_way;
    logic [23:0]     order_out;

    int checks;
    int failures;

    vc_lru_tracker #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_done    (init_done),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_set      (req_set),
        .req_way      (req_way),
        .query_valid  (query_valid),
        .query_set    (query_set),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .order_out    (order_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: ord[s][i] is the way in slot i of set s
    int          ord [SETS][WAYS];
    int          m_cnt;
    bit          m_idle;
    bit          exp_vv;
    logic [23:0] exp_ord;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int i = 0; i < WAYS; i++) ord[s][i] = i;
        m_cnt   = 0;
        m_idle  = 0;
        exp_vv  = 0;
        exp_ord = '0;
    endtask

    task automatic model_apply(int s, int w, bit op);
        int q[$];
        int p;
        q = {};
        p = 0;
        for (int i = 0; i < WAYS; i++) begin
            q.push_back(ord[s][i]);
            if (ord[s][i] == w) p = i;
        end
        q.delete(p);
        if (!op) q.push_front(w);
`ifdef VC_LRU_INVAL_EN
        else q.push_back(w);
`else
        else q.insert(p, w);
`endif
        for (int i = 0; i < WAYS; i++) ord[s][i] = q[i];
    endtask

    // Per-cycle compare, then advance the model using the inputs of the next edge
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_victim_valid", 32'(victim_valid), 0);
            check("rst_order_out", 32'(order_out), 0);
            check("rst_victim_way", 32'(victim_way), 0);
            check("rst_init_done", 32'(init_done), 0);
            check("rst_req_ready", 32'(req_ready), 0);
            model_reset();
        end else begin
            check("victim_valid", 32'(victim_valid), 32'(exp_vv));
            check("order_out", 32'(order_out), 32'(exp_ord));
            check("victim_way", 32'(victim_way), 32'(exp_ord[23:21]));
            check("init_done", 32'(init_done), 32'(m_idle));
            check("req_ready", 32'(req_ready), 32'(m_idle));
            if (!m_idle) begin
                exp_vv = 0;
                m_cnt++;
                if (m_cnt == SETS) m_idle = 1;
            end else begin
                if (req_valid) model_apply(int'(req_set), int'(req_way), req_op);
                exp_vv = query_valid;
                if (query_valid)
                    for (int i = 0; i < WAYS; i++)
                        exp_ord[i*3 +: 3] = 3'(ord[int'(query_set)][i]);
            end
        end
    end

    task automatic step(bit rv, bit op, int s, int w, bit qv, int qs);
        @(posedge clk);
        #2;
        req_valid   = rv;
        req_op      = op;
        req_set     = SETW'(s);
        req_way     = IDXW'(w);
        query_valid = qv;
        query_set   = SETW'(qs);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic query_lit(string name, int s, int vic, logic [23:0] ord_req);
        step(0, 0, 0, 0, 1, s);
        idle_step();
        check({name, "_valid"}, 32'(victim_valid), 1);
        check({name, "_victim"}, 32'(victim_way), 32'(vic));
        if (ord_req !== 'x) check({name, "_order"}, 32'(order_out), 32'(ord_req));
    endtask

    task automatic wait_init(string name);
        int k;
        int first;
        first = 0;
        k = 0;
        while (first == 0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (init_done) first = k;
        end
        check(name, 32'(first), 4);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 0;
        req_valid   = 0;
        req_op      = 0;
        req_set     = '0;
        req_way     = '0;
        query_valid = 0;
        query_set   = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        wait_init("init_latency");
        #1;

        query_lit("reset_q0", 0, 7, 24'o76543210);

        step(1, 0, 0, 7, 0, 0);
        query_lit("touch7", 0, 6, 24'o65432107);
        for (int w = 6; w >= 0; w--) step(1, 0, 0, w, 0, 0);
        query_lit("touch_all", 0, 7, 24'o76543210);

        step(1, 0, 0, 3, 0, 0);
        query_lit("touch3", 0, 7, 24'o76542103);
        query_lit("set1_same", 1, 7, 24'o76543210);

        step(1, 1, 0, 0, 0, 0);
`ifdef VC_LRU_INVAL_EN
        query_lit("inval0", 0, 0, 24'o07654213);
`else
        query_lit("inval0", 0, 7, 24'o76542103);
`endif

        step(1, 0, 2, 7, 1, 2);
        idle_step();
        check("fwd_same_set", 32'(victim_way), 6);
        step(1, 0, 2, 6, 1, 3);
        idle_step();
        check("fwd_other_set", 32'(victim_way), 7);

        step(1, 0, 1, 4, 1, 1);
        step(1, 0, 1, 5, 0, 0);
        step(1, 0, 1, 6, 1, 1);
        @(posedge clk);
        #2 rst_n = 0;
        idle_step();
        #1 check("rst_mid_upd_valid", 32'(victim_valid), 0);
        step(0, 0, 0, 0, 0, 0);
        rst_n = 1;
        idle_step();
        idle_step();
        rst_n = 0;
        idle_step();
        rst_n = 1;
        wait_init("init_after_sweep_rst");
        #1;
        for (int s = 0; s < SETS; s++)
            query_lit("restored", s, 7, 24'o76543210);

        repeat (2) idle_step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
